tmp_dig_mc: RTL and testbench

TMP_DIG_MC -- requirements
Module: tmp_dig_mc

---
 rtl/tmp_dig_mc.sv | 265 ++++++++++++++++++++++++++
 tb/tb_tmp_dig_mc.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmp_dig_mc.sv
// ---------------------------------------------------------------------------
// tmp_dig_mc : digital controller for a chopped multi-channel temperature
// sensor front end.  For every enabled channel it precharges the capacitor
// array, then cycles DIODE / BIGDIODE phases separated by non-overlap blank
// cycles.  The comparator decision taken at the end of each BIGDIODE phase
// first drives a setup period (SETUP_N zero decisions), then NCONV counted
// conversions whose number of ones becomes the channel result.
//
// Ports
//   clk            : single clock, rising edge
//   reset          : asynchronous, active-low reset
//   cmp            : comparator decision
//   start          : single-shot scan request (honoured only in IDLE)
//   cont           : continuous rescan mode
//   en_mask[NCH]   : channel enables, latched at the start of every scan
//   res_ready      : result sink ready
//   PI1/PI2        : big-diode phase switches
//   PII1/PII2      : diode phase switches
//   PA..PD         : capacitor-array switches
//   src_n/snk      : chopped current source / sink controls
//   preChrg        : precharge strobe
//   ch_sel[CHW]    : analog mux channel select
//   res_valid, res_data[RESW], res_ch[CHW] : result handshake
//   busy           : high whenever the controller is not IDLE
// ---------------------------------------------------------------------------
module tmp_dig_mc #(
    parameter int NCH       = 4,
    parameter int NCONV     = 32,
    parameter int SETUP_N   = 6,
    parameter int DIODE_CYC = 1,
    parameter int BIG_CYC   = 2,
    localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int RESW     = $clog2(NCONV + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmp,
    input  logic            start,
    input  logic            cont,
    input  logic [NCH-1:0]  en_mask,
    input  logic            res_ready,
    output logic            PI1,
    output logic            PI2,
    output logic            PII1,
    output logic            PII2,
    output logic            PA,
    output logic            PB,
    output logic            PC,
    output logic            PD,
    output logic            src_n,
    output logic            snk,
    output logic            preChrg,
    output logic [CHW-1:0]  ch_sel,
    output logic            res_valid,
    output logic [RESW-1:0] res_data,
    output logic [CHW-1:0]  res_ch,
    output logic            busy
);

    localparam int PHMAX = (DIODE_CYC > BIG_CYC) ? DIODE_CYC : BIG_CYC;
    localparam int PHW   = (PHMAX > 1) ? $clog2(PHMAX) : 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PRECHARGE,
        ST_BLANK_D,
        ST_DIODE,
        ST_BLANK_B,
        ST_BIGDIODE,
        ST_HCHARGE,
        ST_LCHARGE,
        ST_OUTPUT
    } state_t;

    // Lowest set bit of a channel mask (0 when the mask is empty).
    function automatic logic [CHW-1:0] lowestCh(input logic [NCH-1:0] m);
        lowestCh = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) lowestCh = CHW'(i);
        end
    endfunction

    // Next enabled channel strictly above cur; MSB of the result flags "found".
    function automatic logic [CHW:0] nextCh(input logic [NCH-1:0] m,
                                            input logic [CHW-1:0] cur);
        nextCh = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) nextCh = {1'b1, CHW'(i)};
        end
    endfunction

    state_t          r_state, w_state;
    logic [NCH-1:0]  r_mask, w_mask;
    logic [CHW-1:0]  r_ch, w_ch;
    logic [RESW-1:0] r_acc, w_acc;
    logic [RESW-1:0] r_conv, w_conv;
    logic [5:0]      r_setupCnt, w_setupCnt;
    logic            r_setupDone, w_setupDone;
    logic [PHW-1:0]  r_phCnt, w_phCnt;
    logic [CHW:0]    w_nextCh;

    logic r_pi, r_pii, r_pa, r_pb, r_pc, r_pd, r_preChrg;
    logic w_pi, w_pii, w_pa, w_pb, w_pc, w_pd, w_preChrg;
    logic r_src, r_snk;
    logic r_valid, w_valid;
    logic [RESW-1:0] r_resData, w_resData;
    logic [CHW-1:0]  r_resCh, w_resCh;
    logic r_busy, w_busy;

    // Next-state logic plus the output values that belong to the next state,
    // so every output is a flop aligned with the state register.
    always_comb begin
        w_state     = r_state;
        w_mask      = r_mask;
        w_ch        = r_ch;
        w_acc       = r_acc;
        w_conv      = r_conv;
        w_setupCnt  = r_setupCnt;
        w_setupDone = r_setupDone;
        w_phCnt     = '0;
        w_nextCh    = nextCh(r_mask, r_ch);

        case (r_state)
            ST_IDLE: begin
                if ((start | cont) && (en_mask != '0)) begin
                    w_mask  = en_mask;
                    w_ch    = lowestCh(en_mask);
                    w_state = ST_PRECHARGE;
                end
            end
            ST_PRECHARGE: begin
                w_acc       = '0;
                w_conv      = '0;
                w_setupCnt  = '0;
                w_setupDone = 1'b0;
                w_state     = ST_BLANK_D;
            end
            ST_BLANK_D: w_state = ST_DIODE;
            ST_DIODE: begin
                if (r_phCnt == PHW'(DIODE_CYC - 1)) w_state = ST_BLANK_B;
                else                                w_phCnt = r_phCnt + PHW'(1);
            end
            ST_BLANK_B: w_state = ST_BIGDIODE;
            ST_BIGDIODE: begin
                // Only the last BIGDIODE cycle carries the decision.
                if (r_phCnt == PHW'(BIG_CYC - 1)) begin
                    if (!r_setupDone) begin
                        if (!cmp) begin
                            w_setupCnt = r_setupCnt + 6'd1;
                            if (r_setupCnt == 6'(SETUP_N - 1)) w_setupDone = 1'b1;
                        end
                        w_state = ST_BLANK_D;
                    end else begin
                        w_conv = r_conv + RESW'(1);
                        if (cmp && (r_acc != RESW'(NCONV))) w_acc = r_acc + RESW'(1);
                        w_state = cmp ? ST_HCHARGE : ST_LCHARGE;
                    end
                end else begin
                    w_phCnt = r_phCnt + PHW'(1);
                end
            end
            ST_HCHARGE, ST_LCHARGE: begin
                w_state = (r_conv == RESW'(NCONV)) ? ST_OUTPUT : ST_BLANK_D;
            end
            ST_OUTPUT: begin
                if (r_valid && res_ready) begin
                    if (w_nextCh[CHW]) begin
                        w_ch    = w_nextCh[CHW-1:0];
                        w_state = ST_PRECHARGE;
                    end else if (cont) begin
                        // Rescan picks up whatever mask is presented right now.
                        w_mask  = en_mask;
                        w_ch    = lowestCh(en_mask);
                        w_state = (en_mask != '0) ? ST_PRECHARGE : ST_IDLE;
                    end else begin
                        w_state = ST_IDLE;
                    end
                end
            end
            default: w_state = ST_IDLE;
        endcase

        w_pi      = (w_state == ST_BIGDIODE);
        w_pii     = (w_state == ST_DIODE);
        w_pa      = (w_state inside {ST_PRECHARGE, ST_HCHARGE, ST_LCHARGE});
        w_pb      = (w_state inside {ST_PRECHARGE, ST_HCHARGE, ST_OUTPUT});
        w_pc      = (w_state inside {ST_PRECHARGE, ST_LCHARGE, ST_OUTPUT});
        w_pd      = (w_state inside {ST_PRECHARGE, ST_OUTPUT});
        w_preChrg = (w_state == ST_PRECHARGE);
        w_valid   = (w_state == ST_OUTPUT);
        w_resData = (w_state == ST_OUTPUT) ? w_acc : '0;
        w_resCh   = (w_state == ST_OUTPUT) ? w_ch : '0;
        w_busy    = (w_state != ST_IDLE);
    end

    // State, datapath and output registers.  The chopper controls toggle on
    // every clock spent in BIGDIODE, steered by the comparator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_mask      <= '0;
            r_ch        <= '0;
            r_acc       <= '0;
            r_conv      <= '0;
            r_setupCnt  <= '0;
            r_setupDone <= 1'b0;
            r_phCnt     <= '0;
            r_pi        <= 1'b0;
            r_pii       <= 1'b0;
            r_pa        <= 1'b0;
            r_pb        <= 1'b0;
            r_pc        <= 1'b0;
            r_pd        <= 1'b0;
            r_preChrg   <= 1'b0;
            r_src       <= 1'b0;
            r_snk       <= 1'b0;
            r_valid     <= 1'b0;
            r_resData   <= '0;
            r_resCh     <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_mask      <= w_mask;
            r_ch        <= w_ch;
            r_acc       <= w_acc;
            r_conv      <= w_conv;
            r_setupCnt  <= w_setupCnt;
            r_setupDone <= w_setupDone;
            r_phCnt     <= w_phCnt;
            r_pi        <= w_pi;
            r_pii       <= w_pii;
            r_pa        <= w_pa;
            r_pb        <= w_pb;
            r_pc        <= w_pc;
            r_pd        <= w_pd;
            r_preChrg   <= w_preChrg;
            r_valid     <= w_valid;
            r_resData   <= w_resData;
            r_resCh     <= w_resCh;
            r_busy      <= w_busy;
            if (r_state == ST_BIGDIODE) begin
                r_src <= r_src ^ cmp;
                r_snk <= r_snk ^ ~cmp;
            end
        end
    end

    assign PI1       = r_pi;
    assign PI2       = r_pi;
    assign PII1      = r_pii;
    assign PII2      = r_pii;
    assign PA        = r_pa;
    assign PB        = r_pb;
    assign PC        = r_pc;
    assign PD        = r_pd;
    assign preChrg   = r_preChrg;
    assign src_n     = r_src;
    assign snk       = r_snk;
    assign ch_sel    = r_ch;
    assign res_valid = r_valid;
    assign res_data  = r_resData;
    assign res_ch    = r_resCh;
    assign busy      = r_busy;

endmodule

// File: tb/tb_tmp_dig_mc.sv
// ---------------------------------------------------------------------------
// tb_tmp_dig_mc : scoreboard bench for tmp_dig_mc.  A monitor process drives
// the comparator once per BIGDIODE phase, records each decision in a per-
// channel decision list, and when a channel has seen SETUP_N zeros followed by
// NCONV decisions it pushes the expected (channel, count-of-ones) pair into a
// queue.  The same monitor pops and compares whenever the DUT offers a result.
// ---------------------------------------------------------------------------
module tb_tmp_dig_mc;

    localparam int NCH       = 4;
    localparam int NCONV     = 32;
    localparam int SETUP_N   = 6;
    localparam int DIODE_CYC = 1;
    localparam int BIG_CYC   = 2;
    localparam int CHW       = 2;
    localparam int RESW      = 6;
    localparam int WAIT_MAX  = 8000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cmp = 1'b0;
    logic start = 1'b0;
    logic cont = 1'b0;
    logic [NCH-1:0] en_mask = '0;
    logic res_ready = 1'b0;
    logic PI1, PI2, PII1, PII2, PA, PB, PC, PD, src_n, snk, preChrg;
    logic [CHW-1:0] ch_sel;
    logic res_valid;
    logic [RESW-1:0] res_data;
    logic [CHW-1:0] res_ch;
    logic busy;

    tmp_dig_mc #(
        .NCH(NCH), .NCONV(NCONV), .SETUP_N(SETUP_N),
        .DIODE_CYC(DIODE_CYC), .BIG_CYC(BIG_CYC)
    ) dut (
        .clk(clk), .reset(reset), .cmp(cmp), .start(start), .cont(cont),
        .en_mask(en_mask), .res_ready(res_ready),
        .PI1(PI1), .PI2(PI2), .PII1(PII1), .PII2(PII2),
        .PA(PA), .PB(PB), .PC(PC), .PD(PD),
        .src_n(src_n), .snk(snk), .preChrg(preChrg), .ch_sel(ch_sel),
        .res_valid(res_valid), .res_data(res_data), .res_ch(res_ch), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int ch; int data; } exp_t;

    int   errors = 0;
    int   checks = 0;
    exp_t expQ[$];
    int   chQ[$];
    int   decQ[$];
    int   scanRem = 0;
    int   handshakes = 0;
    int   cmpMode = 0;
    int   readyMode = 0;
    int   stallCnt = 0;

    logic       expSrc = 1'b0;
    logic       expSnk = 1'b0;
    logic       prevPI = 1'b0;
    logic       prevPII = 1'b0;
    logic [8:0] prevVec = '0;
    int         piRun = 0;
    int         piiRun = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got no event expected event within bound", name);
    endtask

    // A scan visits the enabled channels in ascending order.
    task automatic pushScan(input logic [NCH-1:0] m);
        for (int i = 0; i < NCH; i++) if (m[i]) chQ.push_back(i);
        scanRem = $countones(m);
    endtask

    // Index of the first counted conversion, or -1 while still in setup.
    function automatic int postSetupStart();
        int z = 0;
        foreach (decQ[i]) begin
            if (decQ[i] == 0) begin
                z++;
                if (z == SETUP_N) return i + 1;
            end
        end
        return -1;
    endfunction

    function automatic logic pickCmp();
        int s = postSetupStart();
        int post = (s < 0) ? 0 : (decQ.size() - s);
        case (cmpMode)
            1:       return (s < 0) ? 1'b0 : 1'b1;
            2:       return 1'b0;
            3:       return (s < 0) ? 1'b0 : ((post % 2) == 0);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic recordDecision(input logic d);
        int s;
        exp_t e;
        decQ.push_back(int'(d));
        s = postSetupStart();
        if (s >= 0 && decQ.size() == s + NCONV) begin
            e.data = 0;
            for (int i = s; i < decQ.size(); i++) e.data += decQ[i];
            if (e.data > NCONV) e.data = NCONV;
            if (chQ.size() == 0) begin
                failNow("conversionWithoutChannel");
                e.ch = -1;
            end else begin
                e.ch = chQ.pop_front();
            end
            expQ.push_back(e);
            decQ.delete();
        end
    endtask

    // Monitor: phase rules, chopper model, comparator drive, result scoreboard.
    always @(negedge clk) begin
        logic [8:0] vec;
        logic r;
        vec = {PA, PB, PC, PD, preChrg, PI1, PI2, PII1, PII2};
        if (!reset) begin
            expSrc  = 1'b0;
            expSnk  = 1'b0;
            prevPI  = 1'b0;
            prevPII = 1'b0;
            prevVec = '0;
            piRun   = 0;
            piiRun  = 0;
        end else begin
            if (prevPI) begin
                expSrc = expSrc ^ cmp;
                expSnk = expSnk ^ ~cmp;
            end
            checkOutput("src_n", src_n, expSrc);
            checkOutput("snk", snk, expSnk);

            if (PI1) checkOutput("bigPhaseSwitches", {PA, PB, PC, PD, preChrg, PII1, PII2, ~PI2}, 0);
            else     checkOutput("pi2Low", PI2, 0);
            if (PII1) checkOutput("diodePhaseSwitches", {PA, PB, PC, PD, preChrg, PI1, PI2, ~PII2}, 0);
            else      checkOutput("pii2Low", PII2, 0);
            if (PI1 && !prevPI)   checkOutput("blankBeforeBig", prevVec, 0);
            if (PII1 && !prevPII) checkOutput("blankBeforeDiode", prevVec, 0);

            if (PI1) piRun++;
            else if (prevPI) begin
                checkOutput("bigWidth", piRun, BIG_CYC);
                piRun = 0;
            end
            if (PII1) piiRun++;
            else if (prevPII) begin
                checkOutput("diodeWidth", piiRun, DIODE_CYC);
                piiRun = 0;
            end

            if (PI1 && !prevPI) begin
                cmp = pickCmp();
                recordDecision(cmp);
            end

            case (readyMode)
                1: begin
                    r = (stallCnt >= 10);
                    if (res_valid && stallCnt < 10) stallCnt++;
                end
                2:       r = 1'($urandom_range(0, 1));
                default: r = 1'b1;
            endcase
            res_ready = r;

            if (res_valid) begin
                if (expQ.size() == 0) begin
                    failNow("unexpectedResult");
                end else begin
                    checkOutput("res_data", res_data, expQ[0].data);
                    checkOutput("res_ch", res_ch, expQ[0].ch);
                    checkOutput("outputSwitches", {PA, PB, PC, PD, preChrg, PI1, PII1}, 7'b0111000);
                    if (res_ready) begin
                        void'(expQ.pop_front());
                        handshakes++;
                        scanRem--;
                        if (scanRem == 0 && cont && en_mask != '0) pushScan(en_mask);
                    end
                end
            end

            prevPI  = PI1;
            prevPII = PII1;
            prevVec = vec;
        end
    end

    task automatic waitIdle(input string name);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(busy == 1'b0 && scanRem == 0 && expQ.size() == 0) && n < WAIT_MAX);
        if (n >= WAIT_MAX) failNow(name);
    endtask

    task automatic waitHandshakes(input int target, input string name);
        int n = 0;
        while (handshakes < target && n < WAIT_MAX) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= WAIT_MAX) failNow(name);
    endtask

    // One single-shot scan; optionally pokes start/en_mask mid-scan.
    task automatic applyStimulus(input logic [NCH-1:0] m, input int cMode,
                                 input int rMode, input bit disturb, input string name);
        int hs0 = handshakes;
        cmpMode   = cMode;
        readyMode = rMode;
        stallCnt  = 0;
        en_mask   = m;
        start     = 1'b1;
        pushScan(m);
        @(posedge clk); #1;
        start = 1'b0;
        if (disturb) begin
            repeat (50) @(posedge clk);
            #1;
            start   = 1'b1;
            en_mask = ~m;
            @(posedge clk); #1;
            start = 1'b0;
        end
        waitIdle({name, "Timeout"});
        checkOutput({name, "Busy"}, busy, 0);
        checkOutput({name, "Results"}, handshakes - hs0, $countones(m));
    endtask

    initial begin
        logic [NCH-1:0] m;
        int hs0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetOutputs",
            {PI1, PI2, PII1, PII2, PA, PB, PC, PD, src_n, snk, preChrg, ch_sel,
             res_valid, res_data, res_ch, busy}, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idleAfterReset", busy, 0);

        $display("[TB] directed scans");
        applyStimulus(4'b0101, 1, 0, 1'b0, "allOnes");
        applyStimulus(4'b1000, 2, 0, 1'b0, "allZeros");
        applyStimulus(4'b0010, 3, 0, 1'b0, "alternating");
        applyStimulus(4'b1001, 0, 1, 1'b0, "readyStall");

        $display("[TB] random scans");
        for (int k = 0; k < 4; k++) begin
            m = 4'($urandom_range(1, 15));
            applyStimulus(m, 0, 2, (k % 2) == 1, "randomScan");
        end

        $display("[TB] continuous mode");
        cmpMode   = 0;
        readyMode = 2;
        en_mask   = 4'b1011;
        hs0       = handshakes;
        cont      = 1'b1;
        pushScan(4'b1011);
        waitHandshakes(hs0 + 4, "contSecondScan");
        #1;
        en_mask = 4'($urandom_range(1, 15));
        waitHandshakes(hs0 + 7, "contThirdScan");
        cont = 1'b0;
        waitIdle("contTimeout");
        checkOutput("contBusy", busy, 0);

        $display("[TB] empty mask in continuous mode");
        en_mask = '0;
        cont    = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            checkOutput("emptyMaskIdle", busy, 0);
        end
        cont = 1'b0;

        $display("[TB] reset during BIGDIODE");
        cmpMode   = 0;
        readyMode = 0;
        en_mask   = 4'b0001;
        start     = 1'b1;
        pushScan(4'b0001);
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int n = 0;
            while (!PI1 && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 200) failNow("bigDiodeNeverSeen");
        end
        reset = 1'b0;
        #1;
        checkOutput("resetMidBig",
            {PI1, PI2, PII1, PII2, PA, PB, PC, PD, src_n, snk, preChrg, ch_sel,
             res_valid, res_data, res_ch, busy}, 0);
        expQ.delete();
        chQ.delete();
        decQ.delete();
        scanRem = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            checkOutput("idleAfterRelease", {busy, res_valid, preChrg}, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 100000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
